uart_tx_engine: RTL

UART transmit serializer that drains the TX FIFO and drives the serial line. It pops one word from the FIFO read port whenever the FIFO is non-empty and the engine is idle. Each word is sent as a frame: start bit, Data_bits data bits LSB first, optional parity, then 1 or 2 stop bits. Bit timing comes from the shared oversampling baud tick (s_tick), the same tick the receive path uses.

---
 rtl/uart_tx_engine.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops show-ahead FIFO words and sends start/data/parity/stop frames on tx.
// Bit timing from the shared oversampling s_tick; tx is registered and falls on the pop edge.
module uart_tx_engine #(
    parameter int Data_bits = 8,
    parameter int Sb_ticks  = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 s_tick,
    input  logic                 fifo_empty,
    input  logic [Data_bits-1:0] fifo_r_data,
    output logic                 fifo_rd,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 stop2,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);
    localparam int TW = $clog2(2 * Sb_ticks);
    localparam int BW = (Data_bits > 1) ? $clog2(Data_bits) : 1;
    localparam logic [TW-1:0] TICK_LAST1 = TW'(Sb_ticks - 1);
    localparam logic [TW-1:0] TICK_LAST2 = TW'(2 * Sb_ticks - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(Data_bits - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [Data_bits-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 pen_q, pen_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;

    // Only the second-stop case stretches the bit period to two.
    assign bit_end = s_tick &&
                     (tick_q == ((state_q == S_STOP && stop2_q) ? TICK_LAST2 : TICK_LAST1));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            pen_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            pen_q   <= pen_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        pen_d   = pen_q;
        stop2_d = stop2_q;
        if (state_q != S_IDLE && s_tick) begin
            tick_d = bit_end ? '0 : tick_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_START;
                    shift_d = fifo_r_data;
                    par_d   = (^fifo_r_data) ^ parity_odd;
                    pen_d   = parity_en;
                    stop2_d = stop2;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) state_d = pen_q ? S_PARITY : S_STOP;
                    else                   bit_d   = bit_q + 1'b1;
                end
            end
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // tx_d follows the next state so the line changes on the transition edge itself.
    always_comb begin
        fifo_rd      = (state_q == S_IDLE) && !fifo_empty && !Reset;
        tx_busy      = (state_q != S_IDLE);
        tx_done_tick = (state_q == S_STOP) && bit_end;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;
endmodule
